// File: rtl/uart_pkg.sv
// Shared uart register map: transmitter/config indices plus the RX FIFO window
// (DATA, STATUS, CTRL, IRQ_THR) and its STATUS/CTRL bit positions.
package uart_pkg;

    typedef logic [2:0] reg_idx_t;

    // Existing uart transmitter/config register indices.
    localparam reg_idx_t UART_TX_DATA    = 3'd0;
    localparam reg_idx_t UART_TX_STATUS  = 3'd1;
    localparam reg_idx_t UART_BAUD_DIV   = 3'd2;

    // RX FIFO register window.
    localparam reg_idx_t UART_RX_DATA    = 3'd0;
    localparam reg_idx_t UART_RX_STATUS  = 3'd1;
    localparam reg_idx_t UART_RX_CTRL    = 3'd2;
    localparam reg_idx_t UART_RX_IRQ_THR = 3'd3;

    localparam int STAT_EMPTY_BIT   = 0;
    localparam int STAT_FULL_BIT    = 1;
    localparam int STAT_OVR_BIT     = 2;
    localparam int STAT_COUNT_LSB   = 8;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVR_BIT = 1;

    // Count is passed zero-extended so bits above the real count width read 0.
    function automatic logic [31:0] status_word(input logic        empty,
                                                input logic        full,
                                                input logic        ovr,
                                                input logic [23:0] count);
        logic [31:0] w;
        w                        = '0;
        w[STAT_EMPTY_BIT]        = empty;
        w[STAT_FULL_BIT]         = full;
        w[STAT_OVR_BIT]          = ovr;
        w[STAT_COUNT_LSB +: 24]  = count;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// RX byte strobe plus core peripheral bus for uart_rx_fifo.
// The irq line is present only when UART_RX_IRQ_EN is defined.
interface uart_rx_fifo_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        we;
    logic        re;
    logic [2:0]  reg_num;
    logic [31:0] wd;
    logic [31:0] rd;
`ifdef UART_RX_IRQ_EN
    logic        irq;

    modport master (output rx_data, rx_valid, we, re, reg_num, wd,
                    input  rd, irq);
    modport slave  (input  rx_data, rx_valid, we, re, reg_num, wd,
                    output rd, irq);
`else
    modport master (output rx_data, rx_valid, we, re, reg_num, wd,
                    input  rd);
    modport slave  (input  rx_data, rx_valid, we, re, reg_num, wd,
                    output rd);
`endif
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 byte storage: one clocked write port, one asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the uart RX, exposed to the core as DATA/STATUS/CTRL registers.
// Optional threshold/overrun interrupt with IRQ_THR register: define UART_RX_IRQ_EN.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);

    import uart_pkg::*;

    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overrun_q, overrun_d;

    logic          is_empty, is_full;
    logic          pop, push, ovr_set;
    logic          ctrl_wr, flush, ovr_clr, mem_we;
    logic [7:0]    head;
    logic [31:0]   rd_word;
    logic          unused_wd;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    // A pop frees the slot a same-cycle push needs, so a full FIFO accepts it.
    assign pop      = bus.re && !bus.we && (bus.reg_num == UART_RX_DATA) && !is_empty;
    assign push     = bus.rx_valid && (!is_full || pop);
    assign ovr_set  = bus.rx_valid && is_full && !pop;

    assign ctrl_wr  = bus.we && (bus.reg_num == UART_RX_CTRL);
    assign flush    = ctrl_wr && bus.wd[CTRL_FLUSH_BIT];
    assign ovr_clr  = ctrl_wr && bus.wd[CTRL_CLR_OVR_BIT];
    assign mem_we   = push && !flush;

    assign unused_wd = ^bus.wd;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.rx_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // A new overrun beats a same-cycle clear.
        overrun_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
    end

`ifdef UART_RX_IRQ_EN
    logic [CW-1:0] thr_q, thr_d;
    logic          irq_q, irq_d;

    always_comb begin
        thr_d = thr_q;
        if (bus.we && (bus.reg_num == UART_RX_IRQ_THR)) begin
            thr_d = bus.wd[CW-1:0];
        end
        irq_d = ((count_d >= thr_d) && (thr_d != '0)) || overrun_d;
    end

    assign bus.irq = irq_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
`ifdef UART_RX_IRQ_EN
            thr_q     <= CW'(1);
            irq_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
`ifdef UART_RX_IRQ_EN
            thr_q     <= thr_d;
            irq_q     <= irq_d;
`endif
        end
    end

    always_comb begin
        rd_word = '0;
        if (bus.re) begin
            case (bus.reg_num)
                UART_RX_DATA:    rd_word = {24'h0, (is_empty ? 8'h00 : head)};
                UART_RX_STATUS:  rd_word = status_word(is_empty, is_full, overrun_q, 24'(count_q));
`ifdef UART_RX_IRQ_EN
                UART_RX_IRQ_THR: rd_word = 32'(thr_q);
`endif
                default:         rd_word = '0;
            endcase
        end
    end

    assign bus.rd = rd_word;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table for the register map plus scoreboarded
// multi-cycle sequences (full/overrun, push+pop when full, flush, async reset, irq).
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic clk;
    logic rst;

    uart_rx_fifo_if bus();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  model_q[$];
    logic        model_ovr = 1'b0;
    logic [31:0] last_rd;

    typedef struct {
        logic        rxv;
        logic [7:0]  rxd;
        logic        w;
        logic        r;
        logic [2:0]  rn;
        logic [31:0] wdv;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] w;
        w       = '0;
        w[0]    = (model_q.size() == 0);
        w[1]    = (model_q.size() == DEPTH);
        w[2]    = model_ovr;
        w[31:8] = 24'(model_q.size());
        return w;
    endfunction

    // One clock: drive at posedge+1, sample/score at negedge, update the model at the edge.
    task automatic cycle(input logic rxv, input logic [7:0] rxd, input logic w, input logic r,
                         input logic [2:0] rn, input logic [31:0] wdv);
        logic pop_m, flush_m, clr_m, set_m;
        bus.rx_valid = rxv;
        bus.rx_data  = rxd;
        bus.we       = w;
        bus.re       = r;
        bus.reg_num  = rn;
        bus.wd       = wdv;
        @(negedge clk);
        last_rd = bus.rd;
        pop_m   = r && !w && (rn == 3'd0) && (model_q.size() > 0);
        if (r && !w && rn == 3'd0)
            check("sb_data", bus.rd, pop_m ? {24'h0, model_q[0]} : 32'h0);
        if (r && !w && rn == 3'd1)
            check("sb_status", bus.rd, model_status());
        flush_m = w && (rn == 3'd2) && wdv[0];
        clr_m   = w && (rn == 3'd2) && wdv[1];
        set_m   = rxv && (model_q.size() == DEPTH) && !pop_m;
        @(posedge clk);
        if (set_m)      model_ovr = 1'b1;
        else if (clr_m) model_ovr = 1'b0;
        if (flush_m) begin
            model_q.delete();
        end else begin
            if (pop_m) void'(model_q.pop_front());
            if (rxv && model_q.size() < DEPTH) model_q.push_back(rxd);
        end
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic read_reg(input logic [2:0] rn);
        cycle(1'b0, 8'd0, 1'b0, 1'b1, rn, 32'd0);
    endtask

    task automatic write_reg(input logic [2:0] rn, input logic [31:0] wdv);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, rn, wdv);
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.we       = 1'b0;
        bus.re       = 1'b0;
        bus.reg_num  = 3'd0;
        bus.wd       = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_0001};
        vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0000_0000};
        vecs[2]  = '{1'b1, 8'h42, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0000_0000};
        vecs[3]  = '{1'b1, 8'h43, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0000_0000};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_0300};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0041};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0042};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0043};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_0001};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0000};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 32'h0, 32'h0000_0000};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 32'h0, 32'h0000_0000};
`ifdef UART_RX_IRQ_EN
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 32'h0, 32'h0000_0001};
`else
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 32'h0, 32'h0000_0000};
`endif
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_0001};

`ifdef UART_RX_IRQ_EN
        check("irq_reset", {31'b0, bus.irq}, 32'h0);
`endif
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].rxv, vecs[i].rxd, vecs[i].w, vecs[i].r, vecs[i].rn, vecs[i].wdv);
            check($sformatf("vec%0d", i), last_rd, vecs[i].exp);
        end

        // Fill, overrun, clear overrun, drain in order.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        read_reg(3'd1);
        check("full_status", last_rd, 32'h0000_1002);
        push_byte(8'hAA);
        read_reg(3'd1);
        check("overrun_status", last_rd, 32'h0000_1006);
        write_reg(3'd2, 32'h2);
        read_reg(3'd1);
        check("ovr_clear_status", last_rd, 32'h0000_1002);
        for (int i = 0; i < DEPTH; i++) begin
            read_reg(3'd0);
            check("drain_order", last_rd, 32'(i));
        end
        read_reg(3'd1);
        check("drained_status", last_rd, 32'h0000_0001);

        // Push and pop together while full.
        for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i));
        cycle(1'b1, 8'h55, 1'b0, 1'b1, 3'd0, 32'd0);
        check("full_pushpop_data", last_rd, 32'h0000_0080);
        read_reg(3'd1);
        check("full_pushpop_status", last_rd, 32'h0000_1002);
        for (int i = 0; i < DEPTH; i++) read_reg(3'd0);
        check("pushpop_last_byte", last_rd, 32'h0000_0055);

        // Latency and a write to DATA that must not pop.
        push_byte(8'h77);
        cycle(1'b0, 8'd0, 1'b1, 1'b1, 3'd0, 32'd0);
        check("data_we_no_pop", last_rd, 32'h0000_0077);
        read_reg(3'd0);
        check("latency_data", last_rd, 32'h0000_0077);

        // Flush beats a same-cycle push.
        push_byte(8'h11);
        push_byte(8'h22);
        cycle(1'b1, 8'h33, 1'b1, 1'b0, 3'd2, 32'h3);
        read_reg(3'd1);
        check("flush_status", last_rd, 32'h0000_0001);
        read_reg(3'd0);
        check("flush_data", last_rd, 32'h0000_0000);

        // Asynchronous reset with count=5 and overrun set.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        push_byte(8'hEE);
        for (int i = 0; i < DEPTH - 5; i++) read_reg(3'd0);
        read_reg(3'd1);
        check("pre_reset_status", last_rd, 32'h0000_0504);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hC3;
        bus.we       = 1'b0;
        bus.re       = 1'b1;
        bus.reg_num  = 3'd1;
        rst          = 1'b1;
        #1;
        check("rst_status_immediate", bus.rd, 32'h0000_0001);
        @(posedge clk);
        #1;
        check("rst_status_held", bus.rd, 32'h0000_0001);
        rst = 1'b0;
        model_q.delete();
        model_ovr = 1'b0;
        read_reg(3'd1);
        check("post_reset_status", last_rd, 32'h0000_0001);

`ifdef UART_RX_IRQ_EN
        check("irq_after_rst", {31'b0, bus.irq}, 32'h0);
        read_reg(3'd3);
        check("thr_reset", last_rd, 32'h0000_0001);
        write_reg(3'd3, 32'h4);
        read_reg(3'd3);
        check("thr_readback", last_rd, 32'h0000_0004);
        for (int i = 0; i < 3; i++) begin
            push_byte(8'hD0 + 8'(i));
            check("irq_below_thr", {31'b0, bus.irq}, 32'h0);
        end
        push_byte(8'hD3);
        check("irq_at_thr", {31'b0, bus.irq}, 32'h1);
        read_reg(3'd0);
        check("irq_after_pop", {31'b0, bus.irq}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the uart block.
- Captures each byte the uart receiver completes and holds it in a FIFO.
- Presents the FIFO to the single-cycle core as memory-mapped registers selected by reg_num, so software can drain bursts without losing bytes.
- Sits between uart RX output and the core's peripheral read/write bus.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, >= 2.
- AW, $clog2(DEPTH), pointer width. Count width is AW+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rx_data  in  8  byte from uart receiver; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe: byte complete.
- we  in  1  core write enable.
- re  in  1  core read enable.
- reg_num  in  3  register select.
- wd  in  32  core write data.
- rd  out  32  core read data (combinational).
- irq  out  1  RX interrupt; present only with UART_RX_IRQ_EN.

Behaviour:
- Register map:
  - 0 DATA (RO): rd[7:0] = head byte, rd[31:8] = 0. Reads 0 when empty.
  - 1 STATUS (RO): bit0 empty; bit1 full; bit2 overrun; bits[8+AW:8] count; other bits 0.
  - 2 CTRL (WO):
    - wd[0]=1: flush.
    - wd[1]=1: clear overrun.
    - Reads 0.
  - 3 IRQ_THR (RW): only with UART_RX_IRQ_EN, else reads 0.
  - Other regs read 0; writes to them are ignored.
- rd is combinational from state, reg_num and re. rd = 0 whenever re=0.
- Pop:
  - Occurs at the rising edge when re=1, reg_num=0, we=0, and count>0.
  - The core samples rd in the same cycle; the head advances at the edge.
  - One pop per cycle maximum.
- Push:
  - Occurs at the rising edge when rx_valid=1.
  - If count<DEPTH: write at wr_ptr, wr_ptr+1, count+1.
- Full without a simultaneous pop: byte dropped, overrun set (sticky).
- Push and pop in the same cycle:
  - Both occur and count is unchanged.
  - This holds even when full, so no overrun is raised.
  - When empty, only the push occurs.
- Pointers wrap modulo DEPTH. Count saturates at neither end; guarded by the rules above.
- Flush:
  - wr_ptr = rd_ptr = count = 0.
  - Flush overrides a same-cycle push (byte discarded) and a same-cycle pop.
  - Overrun is not touched unless wd[1]=1.
- Overrun: a set event and a clear in the same cycle leaves overrun=1 (set wins).
- Reset values: wr_ptr=0, rd_ptr=0, count=0, overrun=0, irq=0, IRQ_THR=1. Storage array is not reset.
- Reset asserted mid-operation clears all state immediately; no push/pop completes in that cycle.
- Latency: a byte pushed at edge N is readable on DATA in cycle N+1.

Optional Feature:
- Macro: UART_RX_IRQ_EN.
- Defined:
  - irq port exists. IRQ_THR is a register, width AW+1, written via reg_num=3 using wd[AW:0].
  - irq is registered: irq = (count >= IRQ_THR && IRQ_THR != 0) || overrun, updated each edge from next-state values.
  - IRQ_THR = 0 disables the threshold term (overrun still asserts irq).
  - Writing IRQ_THR > DEPTH is allowed; the threshold never triggers.
- Undefined: no irq port, no IRQ_THR storage; reg 3 reads 0 and ignores writes.

Decomposition:
- Shared package (uart_pkg): register index constants UART_RX_DATA=0, UART_RX_STATUS=1, UART_RX_CTRL=2, UART_RX_IRQ_THR=3; STATUS and CTRL bit positions.
- The same package also carries the existing uart register indices, so the core-side decoder uses one source.
- One natural sub-module: sync_fifo_mem (DEPTH x 8 storage, write port plus asynchronous read port). The pointer, count and register logic stays in uart_rx_fifo.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on three rx_valid pulses; read reg 0 three times -> rd = 0x41, 0x42, 0x43; STATUS then = 0x00000001 (empty, count 0).
- Push 16 bytes 0x00..0x0F -> STATUS bit1=1, count=16. Push 0xAA -> overrun=1, 0xAA is absent. Drain returns 0x00..0x0F in order.
- With the FIFO full, apply rx_valid=0x55 and a DATA pop in the same cycle -> count stays 16, overrun stays 0, 0x55 is the last byte drained.
- Push 0x11, 0x22, then write CTRL wd=0x3 with a simultaneous rx_valid=0x33 -> empty, count 0, overrun 0; DATA read returns 0.
- Assert rst for one cycle while count=5 and overrun=1 -> STATUS = 0x00000001 immediately after the rst rising edge.
- (UART_RX_IRQ_EN) Write IRQ_THR=4, push 3 bytes -> irq=0; the 4th push -> irq=1 the cycle after the edge; one pop -> irq=0.
